// File: rtl/iir_inverse_filter.sv
// First-order inverse filter x[n] = y[n] - ((a*y[n-1]) >>> FRAC_W) as a 2-stage valid/ready pipeline.
// Define IIR_INV_SAT_EN to saturate the output and add the sat_flag port; otherwise the output wraps.
module iir_inverse_filter #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 4,
   parameter int FRAC_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [COEF_W-1:0] a,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef IIR_INV_SAT_EN
   ,
   output logic              sat_flag
`endif
);

   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int DIFF_W = DATA_W + COEF_W + 2;

   logic                     r_s1_v;
   logic                     r_s2_v;
   logic signed [DATA_W-1:0] r_y_prev;
   logic signed [DATA_W-1:0] r_s1_y;
   logic signed [PROD_W-1:0] r_s1_prod;
   logic        [DATA_W-1:0] r_out_data;
   logic                     r_sat;

   logic                     w_stall;
   logic                     w_accept;
   logic signed [DATA_W-1:0] w_hist;
   logic signed [COEF_W:0]   w_coef;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [PROD_W-1:0] w_shift;
   logic signed [DIFF_W-1:0] w_diff;
   logic        [DATA_W:0]   w_narrow;

   // Returns {clipped, value}: the exact difference reduced to DATA_W bits.
   function automatic logic [DATA_W:0] narrow(input logic [DIFF_W-1:0] d);
`ifdef IIR_INV_SAT_EN
      logic [DIFF_W-DATA_W:0] top;
      top = d[DIFF_W-1:DATA_W-1];
      if ((&top) || (~|top)) begin
         narrow = {1'b0, d[DATA_W-1:0]};
      end else if (d[DIFF_W-1]) begin
         narrow = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         narrow = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      narrow = {1'b0, d[DATA_W-1:0]};
`endif
   endfunction

   assign w_stall   = r_s2_v & ~out_ready;
   assign in_ready  = ~w_stall;
   assign w_accept  = in_valid & ~w_stall;
   assign out_valid = r_s2_v;
   assign out_data  = r_out_data;
`ifdef IIR_INV_SAT_EN
   assign sat_flag  = r_sat;
`endif

   // A clear in the accept cycle forces zero history for that very sample.
   always_comb begin
      w_hist   = clr ? {DATA_W{1'b0}} : r_y_prev;
      w_coef   = {1'b0, a};
      w_prod   = w_hist * w_coef;
      w_shift  = r_s1_prod >>> FRAC_W;
      w_diff   = {{(DIFF_W-DATA_W){r_s1_y[DATA_W-1]}}, r_s1_y}
               - {{(DIFF_W-PROD_W){w_shift[PROD_W-1]}}, w_shift};
      w_narrow = narrow(w_diff);
   end

   // Stage 1: capture sample and product, track history.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1_v    <= 1'b0;
         r_s1_y    <= {DATA_W{1'b0}};
         r_s1_prod <= {PROD_W{1'b0}};
         r_y_prev  <= {DATA_W{1'b0}};
      end else if (w_accept) begin
         r_s1_v    <= 1'b1;
         r_s1_y    <= in_data;
         r_s1_prod <= w_prod;
         r_y_prev  <= in_data;
      end else begin
         if (!w_stall) begin
            r_s1_v <= 1'b0;
         end
         if (clr) begin
            r_y_prev <= {DATA_W{1'b0}};
         end
      end
   end

   // Stage 2: subtract and narrow into the output register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s2_v     <= 1'b0;
         r_out_data <= {DATA_W{1'b0}};
         r_sat      <= 1'b0;
      end else if (!w_stall) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_out_data <= w_narrow[DATA_W-1:0];
            r_sat      <= w_narrow[DATA_W];
         end
      end
   end

endmodule
